dmem_responder_l2: RTL and testbench

DMEM_RESPONDER_L2 -- requirements
Module: dmem_responder_L2

---
 rtl/dmem_responder_l2.sv | 131 +++++++++++++
 tb/tb_dmem_responder_l2.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_l2.sv
// dmem_responder_l2: single-request data memory responder behind an L2.
// One request is accepted in IDLE. The response follows exactly LATENCY cycles
// after the accepting edge, as a one-cycle pulse in RESP.
// Optional build macro: DMEM_ADDR_CHECK_EN flags addresses beyond the array.
module dmem_responder_l2 #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [MEM_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          eff_we;
  logic [31:0]   eff_addr, eff_wdata;
  logic [AW-1:0] eff_idx;
  logic          eff_oor;
  logic          do_write;
  logic          unused_addr_bits;

  assign accept = req_valid & req_ready;

  // With LATENCY=1 the RESP-entry edge is also the accepting edge, so the
  // request fields must come straight from the ports instead of the capture regs.
  assign eff_we    = (state_q == IDLE) ? req_we    : we_q;
  assign eff_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign eff_idx   = eff_addr[AW+1:2];
  assign unused_addr_bits = ^{eff_addr[1:0], eff_addr[31:AW+2]};

`ifdef DMEM_ADDR_CHECK_EN
  assign eff_oor = |(eff_addr >> (AW + 2));
`else
  assign eff_oor = 1'b0;
`endif

  // Next-state and counter. The counter is decremented on every WAIT edge.
  // The edge that takes it to zero is the edge that enters RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign do_write = enter_resp & eff_we & ~eff_oor & ~reset;

  // Control, capture and response registers. Read data is only nonzero in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      rdata_q <= (enter_resp & ~eff_we & ~eff_oor) ? mem[eff_idx] : 32'd0;
      err_q   <= enter_resp & eff_oor;
    end
  end

  // Memory array has no reset. The write is committed on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (do_write) mem[eff_idx] <= eff_wdata;
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_addr  = resp_valid ? addr_q : 32'd0;
`ifdef DMEM_ADDR_CHECK_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif
  assign busy       = (state_q != IDLE);
  assign req_ready  = (state_q == IDLE) & ~reset;

endmodule

// File: tb/tb_dmem_responder_l2.sv
// Bench for dmem_responder_l2: randomized and directed requests against an
// array model. A second instance with LATENCY=1 covers back-to-back timing.
module tb_dmem_responder_l2;
  localparam int MW  = 1024;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata, resp_addr;

  logic        r1_valid, r1_we;
  logic [31:0] r1_addr, r1_wdata;
  logic        r1_ready, r1_resp_valid, r1_resp_err, r1_busy;
  logic [31:0] r1_resp_rdata, r1_resp_addr;

  int total = 0, fails = 0, cyc = 0;
  logic [31:0] model [MW];
  bit          written [MW];
  int          rc[$];
  logic [31:0] rd[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (r1_resp_valid) begin rc.push_back(cyc); rd.push_back(r1_resp_rdata); end

  dmem_responder_l2 #(.MEM_WORDS(MW), .LATENCY(LAT)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_addr(resp_addr),
    .resp_err(resp_err), .busy(busy));

  dmem_responder_l2 #(.MEM_WORDS(16), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_we(r1_we), .req_addr(r1_addr), .req_wdata(r1_wdata),
    .resp_valid(r1_resp_valid), .resp_rdata(r1_resp_rdata), .resp_addr(r1_resp_addr),
    .resp_err(r1_resp_err), .busy(r1_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit oor_of(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    return a >= 32'(MW * 4);
`else
    return 1'b0;
`endif
  endfunction

  // One request on u0. After acceptance the bench scrambles the inputs and keeps
  // req_valid high, so nothing may be accepted until the IDLE cycle after RESP.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    int n, idx;
    bit oor;
    logic [31:0] exp_rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!resp_valid) begin
        chk("busy_ready", 32'(req_ready), 32'd0);
        chk("busy_outs", resp_rdata | resp_addr | 32'(resp_err), 32'd0);
      end
    end while (!resp_valid && n < 40);
    chk("latency", 32'(n), 32'(LAT));
    idx    = int'((addr >> 2) % MW);
    oor    = oor_of(addr);
    exp_rd = (we || oor) ? 32'd0 : model[idx];
    chk("rdata", resp_rdata, exp_rd);
    chk("raddr", resp_addr, addr);
    chk("rerr", 32'(resp_err), 32'(oor));
    if (we && !oor) begin model[idx] = wd; written[idx] = 1'b1; end
    @(negedge clk);
    chk("idle_after", {29'd0, req_ready, resp_valid, busy}, 32'b100);
    req_valid = 1'b0;
  endtask

  initial begin
    int n, idx;
    bit we;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {28'd0, req_ready, resp_valid, busy, resp_err}, 32'd0);
    chk("rst_data", resp_rdata | resp_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Basic write then read-back.
    txn(1'b1, 32'h10, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0);

    // Random mix over a small window; reads only of words already written.
    for (int k = 0; k < 40; k++) begin
      idx = int'($urandom_range(0, 15));
      we  = !written[idx] || 1'($urandom_range(0, 1));
      txn(we, 32'(idx * 4) | 32'($urandom_range(0, 3)), $urandom);
    end

    // Inputs scrambled after acceptance must not disturb the captured write.
    txn(1'b1, 32'h20, 32'hCAFE0020);
    txn(1'b0, 32'h20, 32'h0);

    // Address above the array: wraps to word 0, or errors when checking is on.
    txn(1'b1, 32'h0, 32'h0BADF00D);
    txn(1'b0, 32'h1000, 32'h0);
    txn(1'b1, 32'h1000, 32'h55AA55AA);
    txn(1'b0, 32'h0, 32'h0);

    // Reset during a write aborts it: no response, memory keeps the old value.
    txn(1'b1, 32'h8, 32'hA5A50008);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_outs", {29'd0, req_ready, resp_valid, busy}, 32'd0);
    end
    reset = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("abort_noresp", 32'(n), 32'd0);
    txn(1'b0, 32'h8, 32'h0);

    // LATENCY=1 instance: W0, W4, then back-to-back reads of 0x0 and 0x4.
    begin
      logic        kwe [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] kad [4]  = '{32'h0, 32'h4, 32'h0, 32'h4};
      logic [31:0] kwd [4]  = '{32'h11110000, 32'h22220004, 32'h0, 32'h0};
      int          acc [4];
      rc.delete(); rd.delete();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        r1_valid = 1'b1; r1_we = kwe[k]; r1_addr = kad[k]; r1_wdata = kwd[k];
        n = 0;
        while (!r1_ready && n < 20) begin @(negedge clk); n++; end
        acc[k] = cyc;
        @(posedge clk); #1;
      end
      r1_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("l1_count", 32'(rc.size()), 32'd4);
      if (rc.size() == 4) begin
        for (int k = 0; k < 4; k++) chk("l1_lat", 32'(rc[k] - acc[k]), 32'd1);
        chk("l1_second", 32'(rc[3] - acc[2]), 32'd3);
        chk("l1_rd0", rd[2], 32'h11110000);
        chk("l1_rd4", rd[3], 32'h22220004);
        chk("l1_wack", rd[0] | rd[1], 32'd0);
      end
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
